// File: rtl/video_pkg.sv
// video_pkg: shared coordinate width, 720p default timing and raster FSM state
// used across the display-side pixel path.
package video_pkg;

  localparam int unsigned COORD_W   = 13;
  localparam int unsigned COORD_MAX = (1 << COORD_W) - 1;

  // 1280x720p60 timing
  localparam int unsigned H_ACTIVE_720P = 1280;
  localparam int unsigned H_FP_720P     = 110;
  localparam int unsigned H_SYNC_720P   = 40;
  localparam int unsigned H_BP_720P     = 220;
  localparam int unsigned V_ACTIVE_720P = 720;
  localparam int unsigned V_FP_720P     = 5;
  localparam int unsigned V_SYNC_720P   = 5;
  localparam int unsigned V_BP_720P     = 20;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } raster_state_t;

  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_raster_gen_if.sv
// video_raster_gen_if: raster timing bundle; the generator is the master,
// downstream pixel stages are slaves.
interface video_raster_gen_if;
  import video_pkg::*;

  logic               run;
  logic [COORD_W-1:0] row;
  logic [COORD_W-1:0] col;
  logic               de;
  logic               hs;
  logic               vs;
  logic               sof;
  logic               eol;
  logic               busy;

  modport master (
    input  run,
    output row, col, de, hs, vs, sof, eol, busy
  );

  modport slave (
    output run,
    input  row, col, de, hs, vs, sof, eol, busy
  );

endinterface

// File: rtl/raster_axis_cnt.sv
// raster_axis_cnt: one raster axis -- wrapping counter with active/sync window
// decode of the current count and a wrap pulse on the advancing last count.
module raster_axis_cnt
  import video_pkg::*;
#(
  parameter int unsigned TOTAL      = H_ACTIVE_720P + H_FP_720P + H_SYNC_720P + H_BP_720P,
  parameter int unsigned ACTIVE     = H_ACTIVE_720P,
  parameter int unsigned SYNC_START = H_ACTIVE_720P + H_FP_720P,
  parameter int unsigned SYNC_LEN   = H_SYNC_720P
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               adv,
  output logic [COORD_W-1:0] cnt,
  output logic               active,
  output logic               sync,
  output logic               at_zero,
  output logic               wrap
);

  localparam logic [COORD_W-1:0] LAST_C   = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] ACTIVE_C = COORD_W'(ACTIVE);
  localparam logic [COORD_W-1:0] SYNC_S_C = COORD_W'(SYNC_START);
  localparam logic [COORD_W-1:0] SYNC_E_C = COORD_W'(SYNC_START + SYNC_LEN - 1);

  logic [COORD_W-1:0] cnt_reg;
  logic               at_last;

  assign at_last = (cnt_reg == LAST_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (adv) begin
      cnt_reg <= at_last ? '0 : cnt_reg + COORD_W'(1);
    end
  end

  assign cnt     = cnt_reg;
  assign active  = (cnt_reg < ACTIVE_C);
  assign sync    = (cnt_reg >= SYNC_S_C) && (cnt_reg <= SYNC_E_C);
  assign at_zero = (cnt_reg == '0);
  assign wrap    = adv && at_last;

endmodule

// File: rtl/video_raster_gen.sv
// video_raster_gen: free-running raster timing source; all outputs registered and
// describe the same (row, col) point. Define RASTER_FRAME_CNT_EN to add frame_cnt.
module video_raster_gen
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_720P,
  parameter int unsigned H_FP     = H_FP_720P,
  parameter int unsigned H_SYNC   = H_SYNC_720P,
  parameter int unsigned H_BP     = H_BP_720P,
  parameter int unsigned V_ACTIVE = V_ACTIVE_720P,
  parameter int unsigned V_FP     = V_FP_720P,
  parameter int unsigned V_SYNC   = V_SYNC_720P,
  parameter int unsigned V_BP     = V_BP_720P,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef RASTER_FRAME_CNT_EN
  output logic [15:0]        frame_cnt,
`endif
  video_raster_gen_if.master vid
);

  // Totals must stay within COORD_MAX; larger parameter sets are not supported.
  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [COORD_W-1:0] H_EOL_C = COORD_W'(H_ACTIVE - 1);

  raster_state_t      state_reg;
  logic               scan;
  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic               h_act, v_act;
  logic               h_sync, v_sync;
  logic               h_zero, v_zero;
  logic               h_wrap, v_wrap;

  logic [COORD_W-1:0] row_reg, col_reg;
  logic               de_reg, hs_reg, vs_reg, sof_reg, eol_reg, busy_reg;

  assign scan = (state_reg == ST_SCAN);

  raster_axis_cnt #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_LEN   (H_SYNC)
  ) u_h_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!scan),
    .adv     (scan),
    .cnt     (h_cnt),
    .active  (h_act),
    .sync    (h_sync),
    .at_zero (h_zero),
    .wrap    (h_wrap)
  );

  // Vertical axis steps once per line, on the horizontal wrap.
  raster_axis_cnt #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_LEN   (V_SYNC)
  ) u_v_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!scan),
    .adv     (h_wrap),
    .cnt     (v_cnt),
    .active  (v_act),
    .sync    (v_sync),
    .at_zero (v_zero),
    .wrap    (v_wrap)
  );

`ifdef RASTER_FRAME_CNT_EN
  logic [15:0] frame_cnt_reg;
  assign frame_cnt = frame_cnt_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      row_reg   <= '0;
      col_reg   <= '0;
      de_reg    <= 1'b0;
      hs_reg    <= ~SYNC_POL;
      vs_reg    <= ~SYNC_POL;
      sof_reg   <= 1'b0;
      eol_reg   <= 1'b0;
      busy_reg  <= 1'b0;
`ifdef RASTER_FRAME_CNT_EN
      frame_cnt_reg <= '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          row_reg  <= '0;
          col_reg  <= '0;
          de_reg   <= 1'b0;
          hs_reg   <= ~SYNC_POL;
          vs_reg   <= ~SYNC_POL;
          sof_reg  <= 1'b0;
          eol_reg  <= 1'b0;
          busy_reg <= 1'b0;
          if (vid.run) begin
            state_reg <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          row_reg  <= v_cnt;
          col_reg  <= h_cnt;
          de_reg   <= h_act && v_act;
          hs_reg   <= h_sync ? SYNC_POL : ~SYNC_POL;
          vs_reg   <= v_sync ? SYNC_POL : ~SYNC_POL;
          sof_reg  <= h_zero && v_zero;
          eol_reg  <= (h_cnt == H_EOL_C) && v_act;
          busy_reg <= 1'b1;
`ifdef RASTER_FRAME_CNT_EN
          if (h_zero && v_zero) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
          end
`endif
          // run is only honoured at the frame boundary; frames are never cut short.
          if (v_wrap && !vid.run) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign vid.row  = row_reg;
  assign vid.col  = col_reg;
  assign vid.de   = de_reg;
  assign vid.hs   = hs_reg;
  assign vid.vs   = vs_reg;
  assign vid.sof  = sof_reg;
  assign vid.eol  = eol_reg;
  assign vid.busy = busy_reg;

endmodule

// File: tb/tb_video_raster_gen.sv
// tb_video_raster_gen: directed bench on a reduced raster (15x8 totals, active-low
// syncs) so whole frames fit in a short run.
module tb_video_raster_gen;
  import video_pkg::*;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2, HT = 15;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1, VT = 8;
  localparam int FRAME = HT * VT;
  localparam logic POL = 1'b0;
  localparam logic NPOL = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  video_raster_gen_if vif();

`ifdef RASTER_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  video_raster_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(POL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef RASTER_FRAME_CNT_EN
    .frame_cnt (frame_cnt),
`endif
    .vid       (vif.master)
  );

  always #5 clk = ~clk;

  // {row, col, de, hs, vs, sof, eol, busy}
  function automatic logic [32:0] snap();
    return {vif.row, vif.col, vif.de, vif.hs, vif.vs, vif.sof, vif.eol, vif.busy};
  endfunction

  task automatic test_reset();
    logic [32:0] want;
    vif.run = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    want = {13'd0, 13'd0, 1'b0, NPOL, NPOL, 1'b0, 1'b0, 1'b0};
    total++;
    if (snap() !== want) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", snap(), want);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({vif.busy, vif.sof} !== 2'b00) begin
      bad++;
      $display("FAIL idle_hold busy,sof got=%b want=00", {vif.busy, vif.sof});
    end
    $display("reset: done");
  endtask

  task automatic test_start();
    vif.run = 1'b1;
    @(negedge clk);
    total++;
    if ({vif.busy, vif.sof, vif.de} !== 3'b000) begin
      bad++;
      $display("FAIL start_latency busy,sof,de got=%b want=000", {vif.busy, vif.sof, vif.de});
    end
    @(negedge clk);
    total++;
    if ({vif.row, vif.col, vif.de, vif.sof, vif.busy, vif.eol} !== {13'd0, 13'd0, 4'b1110}) begin
      bad++;
      $display("FAIL first_pixel row=%0d col=%0d de=%b sof=%b busy=%b eol=%b want 0,0,1,1,1,0",
               vif.row, vif.col, vif.de, vif.sof, vif.busy, vif.eol);
    end
    $display("start: first pixel row=%0d col=%0d sof=%b", vif.row, vif.col, vif.sof);
  endtask

  task automatic test_frame();
    int er, ec;
    int de_cnt, de_err, hs_cnt, hs_err, hs_first, vs_cnt, vs_err, vs_first;
    int eol_cnt, eol_err, sof_cnt, crd_err, busy_low;
    logic e_de, e_hs, e_vs, e_eol;
    de_cnt = 0; de_err = 0; hs_cnt = 0; hs_err = 0; hs_first = -1;
    vs_cnt = 0; vs_err = 0; vs_first = -1; eol_cnt = 0; eol_err = 0;
    sof_cnt = 0; crd_err = 0; busy_low = 0;
    for (int i = 0; i < FRAME; i++) begin
      er = i / HT;
      ec = i % HT;
      e_de  = (ec < HA) && (er < VA);
      e_hs  = (ec >= HA + HF) && (ec < HA + HF + HS);
      e_vs  = (er >= VA + VF) && (er < VA + VF + VS);
      e_eol = (ec == HA - 1) && (er < VA);
      if (vif.row !== 13'(er) || vif.col !== 13'(ec)) crd_err++;
      if (vif.de !== e_de) de_err++;
      if (vif.de === 1'b1) de_cnt++;
      if (vif.hs !== (e_hs ? POL : NPOL)) hs_err++;
      if (vif.hs === POL) hs_cnt++;
      if (vif.hs === POL && hs_first < 0) hs_first = ec;
      if (vif.vs !== (e_vs ? POL : NPOL)) vs_err++;
      if (vif.vs === POL) vs_cnt++;
      if (vif.vs === POL && vs_first < 0) vs_first = er;
      if (vif.eol !== e_eol) eol_err++;
      if (vif.eol === 1'b1) eol_cnt++;
      if (vif.sof === 1'b1) sof_cnt++;
      if (vif.busy !== 1'b1) busy_low++;
      @(negedge clk);
    end
    total++; if (crd_err != 0) begin bad++; $display("FAIL frame_coords bad_pixels=%0d want=0", crd_err); end
    total++; if (de_cnt != HA * VA) begin bad++; $display("FAIL de_count got=%0d want=%0d", de_cnt, HA * VA); end
    total++; if (de_err != 0) begin bad++; $display("FAIL de_window bad_pixels=%0d want=0", de_err); end
    total++; if (hs_cnt != HS * VT) begin bad++; $display("FAIL hs_count got=%0d want=%0d", hs_cnt, HS * VT); end
    total++; if (hs_first != HA + HF) begin bad++; $display("FAIL hs_start_col got=%0d want=%0d", hs_first, HA + HF); end
    total++; if (hs_err != 0) begin bad++; $display("FAIL hs_window bad_pixels=%0d want=0", hs_err); end
    total++; if (vs_cnt != VS * HT) begin bad++; $display("FAIL vs_count got=%0d want=%0d", vs_cnt, VS * HT); end
    total++; if (vs_first != VA + VF) begin bad++; $display("FAIL vs_start_row got=%0d want=%0d", vs_first, VA + VF); end
    total++; if (vs_err != 0) begin bad++; $display("FAIL vs_window bad_pixels=%0d want=0", vs_err); end
    total++; if (eol_cnt != VA || eol_err != 0) begin bad++; $display("FAIL eol count=%0d errs=%0d want=%0d,0", eol_cnt, eol_err, VA); end
    total++; if (sof_cnt != 1) begin bad++; $display("FAIL sof_per_frame got=%0d want=1", sof_cnt); end
    total++; if (busy_low != 0) begin bad++; $display("FAIL busy_in_frame low_cycles=%0d want=0", busy_low); end
    $display("frame: de=%0d hs=%0d vs=%0d eol=%0d sof=%0d", de_cnt, hs_cnt, vs_cnt, eol_cnt, sof_cnt);
  endtask

  task automatic test_back_to_back();
    int gap;
    bit seen;
    total++;
    if ({vif.sof, vif.row, vif.col} !== {1'b1, 13'd0, 13'd0}) begin
      bad++;
      $display("FAIL seamless_sof sof=%b row=%0d col=%0d want 1,0,0", vif.sof, vif.row, vif.col);
    end
    gap = 0;
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      gap++;
      if (vif.sof === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen || gap != FRAME) begin
      bad++;
      $display("FAIL sof_gap got=%0d seen=%b want=%0d", gap, seen, FRAME);
    end
    $display("back_to_back: sof gap=%0d", gap);
  endtask

  task automatic test_stop();
    int steps;
    bit found;
    logic [12:0] prev_row, prev_col;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (vif.row === 13'd2) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vif.run = 1'b0;
    steps = 0;
    prev_row = vif.row;
    prev_col = vif.col;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      steps++;
      if (vif.busy !== 1'b1) break;
      prev_row = vif.row;
      prev_col = vif.col;
    end
    total++;
    if (!found || steps != FRAME - 2 * HT) begin
      bad++;
      $display("FAIL stop_steps got=%0d found=%b want=%0d", steps, found, FRAME - 2 * HT);
    end
    total++;
    if ({prev_row, prev_col} !== {13'(VT - 1), 13'(HT - 1)}) begin
      bad++;
      $display("FAIL stop_last_pixel row=%0d col=%0d want %0d,%0d", prev_row, prev_col, VT - 1, HT - 1);
    end
    total++;
    if (snap() !== {13'd0, 13'd0, 1'b0, NPOL, NPOL, 3'b000}) begin
      bad++;
      $display("FAIL stop_idle got=%h want=%h", snap(), {13'd0, 13'd0, 1'b0, NPOL, NPOL, 3'b000});
    end
    repeat (3) @(negedge clk);
    total++;
    if ({vif.busy, vif.sof} !== 2'b00) begin
      bad++;
      $display("FAIL stop_stays_idle busy,sof got=%b want=00", {vif.busy, vif.sof});
    end
    $display("stop: idle after %0d cycles, last pixel %0d,%0d", steps, prev_row, prev_col);
  endtask

  task automatic test_async_reset();
    bit found;
    int sof_seen;
    vif.run = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (vif.row === 13'd3 && vif.col === 13'd5) begin
        found = 1'b1;
        break;
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (!found || snap() !== {13'd0, 13'd0, 1'b0, NPOL, NPOL, 3'b000}) begin
      bad++;
      $display("FAIL async_clear found=%b got=%h want=%h", found, snap(), {13'd0, 13'd0, 1'b0, NPOL, NPOL, 3'b000});
    end
`ifdef RASTER_FRAME_CNT_EN
    total++;
    if (frame_cnt !== 16'd0) begin
      bad++;
      $display("FAIL frame_cnt_reset got=%0d want=0", frame_cnt);
    end
`endif
    @(negedge clk);
    vif.run = 1'b0;
    rst_n = 1'b1;
    sof_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (vif.sof !== 1'b0 || vif.busy !== 1'b0) sof_seen++;
    end
    total++;
    if (sof_seen != 0) begin
      bad++;
      $display("FAIL no_run_no_sof active_cycles=%0d want=0", sof_seen);
    end
    vif.run = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({vif.sof, vif.row, vif.col} !== {1'b1, 13'd0, 13'd0}) begin
      bad++;
      $display("FAIL restart_sof sof=%b row=%0d col=%0d want 1,0,0", vif.sof, vif.row, vif.col);
    end
    $display("async_reset: cleared at row 3 col 5, restart sof=%b", vif.sof);
  endtask

`ifdef RASTER_FRAME_CNT_EN
  task automatic test_frame_cnt();
    logic [15:0] prev;
    total++;
    if (frame_cnt !== 16'd1) begin
      bad++;
      $display("FAIL frame_cnt_first got=%0d want=1", frame_cnt);
    end
    for (int k = 2; k <= 3; k++) begin
      prev = frame_cnt;
      for (int i = 0; i < 2 * FRAME; i++) begin
        @(negedge clk);
        if (vif.sof === 1'b1) break;
        prev = frame_cnt;
      end
      total++;
      if (prev !== 16'(k - 1) || frame_cnt !== 16'(k)) begin
        bad++;
        $display("FAIL frame_cnt_step before=%0d at_sof=%0d want %0d,%0d", prev, frame_cnt, k - 1, k);
      end
      $display("frame_cnt: sof shows %0d", frame_cnt);
    end
  endtask
`endif

  initial begin
    vif.run = 1'b0;
    test_reset();
    test_start();
    test_frame();
    test_back_to_back();
    test_stop();
    test_async_reset();
`ifdef RASTER_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
